seven_segment_mux_counter: RTL and testbench

// - Multi-digit decimal seconds counter driving a time-multiplexed 7-segment display

---
 rtl/sevseg_pkg.sv | 19 +
 rtl/seven_segment_decoder.sv | 29 ++
 rtl/seven_segment_mux_counter.sv | 145 ++++++++++++++
 tb/tb_seven_segment_mux_counter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sevseg_pkg.sv
// Shared constants for the multiplexed seven-segment counter.
// Segment codes are ordered {g,f,e,d,c,b,a}, active-high.
package sevseg_pkg;

    localparam int BCD_W = 4;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational BCD to seven-segment decoder.
// Ports:
//   bcd  in   4  BCD digit value; 10-15 decode to blank
//   seg  out  7  segments {g,f,e,d,c,b,a}, active-high
module seven_segment_decoder
    import sevseg_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_segment_mux_counter.sv
// Multi-digit BCD up/down counter with a time-multiplexed seven-segment
// display driver.
//
// A programmable prescaler produces a count tick; NUM_DIGITS cascaded BCD
// digits count up or down on each tick. A free-running scan divider steps a
// digit index and the registered select/segment outputs follow one cycle later.
//
// Optional build macro: SEVSEG_LEADING_ZERO_BLANK_EN blanks leading zero
// digits (digit 0 is never blanked).
//
// Ports:
//   clk            in   1             system clock
//   reset          in   1             synchronous, active-high
//   compare_in     in   CNT_W         new prescaler period
//   update_compare in   1             load compare_in; clear prescaler, digits, wrap
//   run            in   1             1 = count, 0 = hold (scan keeps running)
//   count_down     in   1             0 = up, 1 = down
//   io_oeb         out  NUM_DIGITS+7  output enables, always zero (driven)
//   led_out        out  7             segments {g,f,e,d,c,b,a}, registered
//   digit_sel      out  NUM_DIGITS    one-hot digit enable, registered
//   wrap           out  1             one-cycle pulse after a full-counter wrap
module seven_segment_mux_counter
    import sevseg_pkg::*;
#(
    parameter int CNT_W       = 24,
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 1024,
    parameter int DEF_COMPARE = 100
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CNT_W-1:0]        compare_in,
    input  logic                    update_compare,
    input  logic                    run,
    input  logic                    count_down,
    output logic [NUM_DIGITS+6:0]   io_oeb,
    output logic [6:0]              led_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    wrap
);

    localparam int SD_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CNT_W-1:0]            compare;
    logic [CNT_W-1:0]            prescaler;
    logic [CNT_W-1:0]            eff_compare;
    logic                        tick;
    logic [NUM_DIGITS*BCD_W-1:0] digits;
    logic [NUM_DIGITS*BCD_W-1:0] digits_next;
    logic [NUM_DIGITS-1:0]       edge_bits;   // digit at 9 (up) or 0 (down)
    logic [NUM_DIGITS-1:0]       carry_in;    // digit receives carry/borrow
    logic [NUM_DIGITS-1:0]       zero_bits;
    logic [NUM_DIGITS-1:0]       blank;
    logic                        wrap_next;
    logic [SD_W-1:0]             scan_cnt;
    logic [IDX_W-1:0]            scan_idx;
    logic [6:0]                  seg_cur;

    assign io_oeb = '0;

    // A compare of zero behaves like one: tick every cycle.
    assign eff_compare = (compare == '0) ? CNT_W'(1) : compare;
    assign tick        = run && (prescaler == eff_compare - CNT_W'(1));

    // Carry into digit g is the tick ANDed with every lower digit being at
    // its edge value, so the whole cascade settles in one cycle.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        logic [BCD_W-1:0] d;
        assign d            = digits[g*BCD_W +: BCD_W];
        assign edge_bits[g] = count_down ? (d == 4'd0) : (d == 4'd9);
        assign zero_bits[g] = (d == 4'd0);

        if (g == 0) begin : g_first
            assign carry_in[g] = tick;
        end else begin : g_rest
            assign carry_in[g] = tick & (&edge_bits[g-1:0]);
        end

        assign digits_next[g*BCD_W +: BCD_W] =
            !carry_in[g]  ? d :
            edge_bits[g]  ? (count_down ? 4'd9 : 4'd0) :
            count_down    ? d - 4'd1 : d + 4'd1;

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
        if (g == 0) begin : g_noblank
            assign blank[g] = 1'b0;
        end else begin : g_blank
            assign blank[g] = &zero_bits[NUM_DIGITS-1:g];
        end
`else
        assign blank[g] = 1'b0;
`endif
    end

    assign wrap_next = tick & (&edge_bits);

    // Prescaler, compare register and digit cascade.
    always_ff @(posedge clk) begin
        if (reset) begin
            compare   <= CNT_W'(DEF_COMPARE);
            prescaler <= '0;
            digits    <= '0;
            wrap      <= 1'b0;
        end else if (update_compare) begin
            compare   <= compare_in;
            prescaler <= '0;
            digits    <= '0;
            wrap      <= 1'b0;
        end else begin
            wrap <= wrap_next;
            if (run) begin
                prescaler <= tick ? '0 : prescaler + CNT_W'(1);
                digits    <= digits_next;
            end
        end
    end

    seven_segment_decoder u_decoder (
        .bcd (digits[scan_idx*BCD_W +: BCD_W]),
        .seg (seg_cur)
    );

    // Scan divider and index; select and segments are registered together
    // from the same index so they can never be skewed.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt  <= '0;
            scan_idx  <= '0;
            digit_sel <= NUM_DIGITS'(1);
            led_out   <= SEG_0;
        end else begin
            if (scan_cnt == SD_W'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0
                                                                 : scan_idx + IDX_W'(1);
            end else begin
                scan_cnt <= scan_cnt + SD_W'(1);
            end
            digit_sel <= NUM_DIGITS'(1) << scan_idx;
            led_out   <= blank[scan_idx] ? SEG_BLANK : seg_cur;
        end
    end

endmodule

// File: tb/tb_seven_segment_mux_counter.sv
// Self-checking bench for seven_segment_mux_counter (4 digits, scan every
// 4 cycles). Display contents are checked through a scoreboard: the stimulus
// pushes the expected {digit_sel, led_out} for each upcoming refresh and a
// negedge monitor pops and compares on every digit_sel change.
module tb_seven_segment_mux_counter;

    localparam int CNT_W       = 24;
    localparam int NUM_DIGITS  = 4;
    localparam int SCAN_DIV    = 4;
    localparam int DEF_COMPARE = 100;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [CNT_W-1:0]      compare_in = '0;
    logic                  update_compare = 1'b0;
    logic                  run = 1'b0;
    logic                  count_down = 1'b0;
    logic [NUM_DIGITS+6:0] io_oeb;
    logic [6:0]            led_out;
    logic [NUM_DIGITS-1:0] digit_sel;
    logic                  wrap;

    int checks = 0;
    int passes = 0;
    int wrap_total = 0;
    logic [10:0] exp_q[$];
    logic [6:0] seg_tab [10];

    seven_segment_mux_counter #(
        .CNT_W(CNT_W), .NUM_DIGITS(NUM_DIGITS),
        .SCAN_DIV(SCAN_DIV), .DEF_COMPARE(DEF_COMPARE)
    ) dut (
        .clk(clk), .reset(reset), .compare_in(compare_in),
        .update_compare(update_compare), .run(run), .count_down(count_down),
        .io_oeb(io_oeb), .led_out(led_out), .digit_sel(digit_sel), .wrap(wrap)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helper ----------------
    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act == expv) passes++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [NUM_DIGITS-1:0] prev_sel = '0;
    int gap = 0;
    always @(negedge clk) begin
        logic [10:0] e;
        if (!reset) begin
            if (wrap) wrap_total++;
            gap++;
            if (digit_sel != prev_sel) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("digit_sel", int'(digit_sel), int'(e[10:7]));
                    check("led_out", int'(led_out), int'(e[6:0]));
                    check("scan_gap", gap, SCAN_DIV);
                end
                gap = 0;
            end
        end else begin
            gap = 0;
        end
        prev_sel = digit_sel;
    end

    // ---------------- driver tasks ----------------
    task automatic run_cycles(input int n);
        run = 1'b1;
        repeat (n) @(posedge clk);
        #1 run = 1'b0;
    endtask

    task automatic load_compare(input int v);
        compare_in = CNT_W'(v);
        update_compare = 1'b1;
        @(posedge clk);
        #1 update_compare = 1'b0;
    endtask

    function automatic logic [6:0] exp_seg(input int value, input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
        if (k > 0 && value < p) return 7'b0000000;
`endif
        return seg_tab[(value / p) % 10];
    endfunction

    // Freeze counting, align to a fresh refresh of digit 0, then expect the
    // next full rotation 0010, 0100, 1000, 0001 to show 'value'.
    task automatic display_check(input int value);
        logic [NUM_DIGITS-1:0] last;
        bit synced = 0;
        int order [4] = '{1, 2, 3, 0};
        run = 1'b0;
        @(negedge clk);
        last = digit_sel;
        for (int i = 0; i < 100 && !synced; i++) begin
            @(negedge clk);
            if (digit_sel == 4'b0001 && last != 4'b0001) synced = 1;
            last = digit_sel;
        end
        if (!synced) begin
            check("scan_sync_timeout", 0, 1);
            return;
        end
        @(posedge clk);
        #1;
        for (int j = 0; j < 4; j++) begin
            logic [3:0] sel = 4'(1 << order[j]);
            exp_q.push_back({sel, exp_seg(value, order[j])});
        end
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            check("scoreboard_drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w0;
        seg_tab = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_digit_sel", int'(digit_sel), 1);
        check("reset_led_out", int'(led_out), 'h3F);
        check("reset_wrap", int'(wrap), 0);
        check("io_oeb", int'(io_oeb), 0);
        display_check(0);

        // period 5: first tick after 5 cycles, 0010 after 50
        load_compare(5);
        run_cycles(5);
        display_check(1);
        run_cycles(45);
        display_check(10);

        // run=0 keeps prescaler frozen: 3 + (freeze) + 2 = one tick
        run_cycles(3);
        display_check(10);
        repeat (20) @(posedge clk);
        run_cycles(2);
        display_check(11);

        // update_compare on a terminal count: no tick, new period 3
        run_cycles(4);
        run = 1'b1;
        compare_in = CNT_W'(3);
        update_compare = 1'b1;
        @(posedge clk);
        #1 update_compare = 1'b0;
        run = 1'b0;
        display_check(0);
        run_cycles(2);
        display_check(0);
        run_cycles(1);
        display_check(1);

        // down from 0000: wrap to 9999, then 9998
        load_compare(1);
        count_down = 1'b1;
        w0 = wrap_total;
        run_cycles(1);
        repeat (3) @(posedge clk);
        check("wrap_down_pulse", wrap_total - w0, 1);
        display_check(9999);
        w0 = wrap_total;
        run_cycles(1);
        display_check(9998);
        check("no_wrap_9998", wrap_total - w0, 0);

        // compare=0 ticks every cycle; up to 9999 then wrap to 0000
        load_compare(0);
        count_down = 1'b0;
        w0 = wrap_total;
        run_cycles(9999);
        check("no_wrap_to_9999", wrap_total - w0, 0);
        display_check(9999);
        run_cycles(1);
        repeat (3) @(posedge clk);
        check("wrap_up_pulse", wrap_total - w0, 1);
        display_check(0);

        // leading zeros (blanked only with the macro)
        load_compare(1);
        run_cycles(7);
        display_check(7);

        // reset mid-count restores reset values on the next edge
        run = 1'b1;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_digit_sel", int'(digit_sel), 1);
        check("midreset_led_out", int'(led_out), 'h3F);
        check("midreset_wrap", int'(wrap), 0);
        reset = 1'b0;
        run = 1'b0;
        display_check(0);
        run_cycles(DEF_COMPARE - 1);
        display_check(0);
        run_cycles(1);
        display_check(1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Safety bound on total run time.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
